// File: rtl/decode_pkg.sv
// Shared RV32I decode types: opcodes, ALU/immediate/result selectors and the
// control bundle handed to execute.
package decode_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_XOR   = 4'd4,
    ALU_SLL   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_SLT   = 4'd8,
    ALU_SLTU  = 4'd9,
    ALU_PASSB = 4'd10
  } alu_op_e;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_U = 3'd3,
    IMM_J = 3'd4
  } imm_src_e;

  typedef enum logic [1:0] {
    RES_ALU = 2'd0,
    RES_MEM = 2'd1,
    RES_PC4 = 2'd2
  } result_src_e;

  typedef struct packed {
    alu_op_e     alu_op;
    logic        alu_src;
    imm_src_e    imm_src;
    result_src_e result_src;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        jump;
    logic        jalr;
    logic [2:0]  funct3;
    logic        illegal;
  } ctrl_t;

  // alt selects SUB (funct3 000) or SRA (funct3 101); ignored elsewhere.
  function automatic alu_op_e alu_from_f3(input logic [2:0] f3, input logic alt);
    alu_op_e op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/decode_if.sv
// Fetch-side and execute-side handshake of the decode stage.
interface decode_if
  import decode_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] instr_i;
  logic [ADDR_WIDTH-1:0] pc_i;
  logic                  flush_i;
  logic                  out_valid;
  logic                  out_ready;
  ctrl_t                 ctrl_o;
  logic [4:0]            rd_o;
  logic [4:0]            rs1_o;
  logic [4:0]            rs2_o;
  logic [DATA_WIDTH-1:0] imm_o;
  logic [ADDR_WIDTH-1:0] pc_o;

  modport master (
    output in_valid, instr_i, pc_i, flush_i, out_ready,
    input  in_ready, out_valid, ctrl_o, rd_o, rs1_o, rs2_o, imm_o, pc_o
  );

  modport slave (
    input  in_valid, instr_i, pc_i, flush_i, out_ready,
    output in_ready, out_valid, ctrl_o, rd_o, rs1_o, rs2_o, imm_o, pc_o
  );
endinterface

// File: rtl/imm_gen.sv
// RV32I immediate builder for I/S/B/U/J formats, sign-extended to DATA_WIDTH.
module imm_gen
  import decode_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [31:0]           instr,
  input  imm_src_e              imm_src,
  output logic [DATA_WIDTH-1:0] imm
);
  logic [31:0] imm32;

  always_comb begin
    imm32 = '0;
    case (imm_src)
      IMM_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm32 = {instr[31:12], 12'b0};
      IMM_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  assign imm = DATA_WIDTH'($signed(imm32));
endmodule

// File: rtl/decode_stage.sv
// Registered RV32I decode stage: combinational decode into a one-entry
// pipeline register with flush, sticky illegal flag and legal-decode counter.
module decode_stage
  import decode_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  decode_if.slave              bus,
  output logic                 illegal_sticky_o,
  output logic [CNT_WIDTH-1:0] decode_cnt_o
);
  logic [31:0]           ins;
  logic [6:0]            opcode;
  logic [2:0]            f3;
  logic [6:0]            f7;
  ctrl_t                 dec;
  logic [DATA_WIDTH-1:0] imm_d;
  logic                  capture;

  logic                  out_valid_q;
  ctrl_t                 ctrl_q;
  logic [4:0]            rd_q, rs1_q, rs2_q;
  logic [DATA_WIDTH-1:0] imm_q;
  logic [ADDR_WIDTH-1:0] pc_q;
  logic                  sticky_q;
  logic [CNT_WIDTH-1:0]  cnt_q;

  assign ins    = bus.instr_i[31:0];
  assign opcode = ins[6:0];
  assign f3     = ins[14:12];
  assign f7     = ins[31:25];

  always_comb begin
    dec        = '0;
    dec.funct3 = f3;
    case (opcode)
      OPC_OP: begin
        dec.reg_write = 1'b1;
        dec.alu_op    = alu_from_f3(f3, f7[5]);
        if (f7 == 7'b0100000)
          dec.illegal = !(f3 == 3'b000 || f3 == 3'b101);
        else
          dec.illegal = (f7 != 7'b0000000);
      end
      OPC_OP_IMM: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.alu_op    = alu_from_f3(f3, (f3 == 3'b101) && f7[5]);
        if (f3 == 3'b001)
          dec.illegal = (f7 != 7'b0000000);
        else if (f3 == 3'b101)
          dec.illegal = !(f7 == 7'b0000000 || f7 == 7'b0100000);
      end
      OPC_LOAD: begin
        dec.reg_write  = 1'b1;
        dec.mem_read   = 1'b1;
        dec.alu_src    = 1'b1;
        dec.result_src = RES_MEM;
        dec.illegal    = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
      end
      OPC_STORE: begin
        dec.mem_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.imm_src   = IMM_S;
        dec.illegal   = (f3 > 3'b010);
      end
      OPC_BRANCH: begin
        dec.branch  = 1'b1;
        dec.imm_src = IMM_B;
        case (f3[2:1])
          2'b00:   dec.alu_op = ALU_SUB;
          2'b10:   dec.alu_op = ALU_SLT;
          2'b11:   dec.alu_op = ALU_SLTU;
          default: dec.illegal = 1'b1;
        endcase
      end
      OPC_JAL: begin
        dec.jump       = 1'b1;
        dec.reg_write  = 1'b1;
        dec.alu_src    = 1'b1;
        dec.imm_src    = IMM_J;
        dec.result_src = RES_PC4;
      end
      OPC_JALR: begin
        dec.jump       = 1'b1;
        dec.jalr       = 1'b1;
        dec.reg_write  = 1'b1;
        dec.alu_src    = 1'b1;
        dec.result_src = RES_PC4;
        dec.illegal    = (f3 != 3'b000);
      end
      OPC_LUI: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.imm_src   = IMM_U;
        dec.alu_op    = ALU_PASSB;
      end
      OPC_AUIPC: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.imm_src   = IMM_U;
      end
      default: dec.illegal = 1'b1;
    endcase

    if (ins[11:7] == 5'd0)
      dec.reg_write = 1'b0;
    // Illegal ops travel as bubbles so execute can raise the trap without side effects.
    if (dec.illegal) begin
      dec.reg_write = 1'b0;
      dec.mem_read  = 1'b0;
      dec.mem_write = 1'b0;
      dec.branch    = 1'b0;
      dec.jump      = 1'b0;
      dec.jalr      = 1'b0;
    end
  end

  imm_gen #(.DATA_WIDTH(DATA_WIDTH)) u_imm_gen (
    .instr   (ins),
    .imm_src (dec.imm_src),
    .imm     (imm_d)
  );

  assign bus.in_ready = !out_valid_q || bus.out_ready || bus.flush_i;
  assign capture      = bus.in_valid && bus.in_ready && !bus.flush_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      ctrl_q      <= '0;
      rd_q        <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      imm_q       <= '0;
      pc_q        <= '0;
      sticky_q    <= 1'b0;
      cnt_q       <= '0;
    end else if (bus.flush_i) begin
      out_valid_q <= 1'b0;
    end else if (capture) begin
      out_valid_q <= 1'b1;
      ctrl_q      <= dec;
      rd_q        <= ins[11:7];
      rs1_q       <= ins[19:15];
      rs2_q       <= ins[24:20];
      imm_q       <= imm_d;
      pc_q        <= bus.pc_i;
      sticky_q    <= sticky_q | dec.illegal;
      if (!dec.illegal)
        cnt_q <= cnt_q + CNT_WIDTH'(1);
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_valid    = out_valid_q;
  assign bus.ctrl_o       = ctrl_q;
  assign bus.rd_o         = rd_q;
  assign bus.rs1_o        = rs1_q;
  assign bus.rs2_o        = rs2_q;
  assign bus.imm_o        = imm_q;
  assign bus.pc_o         = pc_q;
  assign illegal_sticky_o = sticky_q;
  assign decode_cnt_o     = cnt_q;
endmodule
